// File: rtl/snake_game_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : snake_game_ctrl_if
//  Description : Bundles the IR-receiver, snake-engine and display-side
//                signals of the snake game sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface snake_game_ctrl_if;
    logic [31:0] ir_code;
    logic        ir_valid;
    logic        food_eaten;
    logic        game_over;
    logic        step_en;
    logic [31:0] dir_code;
    logic        eng_rst_n;
    logic [1:0]  state;
    logic [15:0] score;
    logic [2:0]  level;

    modport master (
        output ir_code, ir_valid, food_eaten, game_over,
        input  step_en, dir_code, eng_rst_n, state, score, level
    );

    modport slave (
        input  ir_code, ir_valid, food_eaten, game_over,
        output step_en, dir_code, eng_rst_n, state, score, level
    );
endinterface
`default_nettype wire

// File: rtl/snake_game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : snake_game_ctrl
//  Description : Snake game sequencer - IR key decode, IDLE/PLAY/PAUSE/OVER
//                flow, step strobe, direction filter, score and speed level.
//  Revision    : 1.0 - initial release
// ============================================================================
module snake_game_ctrl #(
    parameter int          TICK_START  = 12_500_000,
    parameter int          TICK_DEC    = 1_000_000,
    parameter int          TICK_MIN    = 2_500_000,
    parameter int          FOOD_PER_LV = 4,
    parameter int          MAX_LEVEL   = 7,
    parameter logic [31:0] K_UP        = 32'h20DF6A95,
    parameter logic [31:0] K_DOWN      = 32'h20DFEA15,
    parameter logic [31:0] K_LEFT      = 32'h20DF1AE5,
    parameter logic [31:0] K_RIGHT     = 32'h20DF9A65,
    parameter logic [31:0] K_OK        = 32'h20DF22DD
) (
    input  logic             clk,
    input  logic             reset,
    snake_game_ctrl_if.slave bus
);
    localparam int TW = $clog2(TICK_START + 1);
    localparam int FW = $clog2(FOOD_PER_LV + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_PLAY  = 2'b01,
        S_PAUSE = 2'b10,
        S_OVER  = 2'b11
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [TW-1:0]        r_tick;
    logic [TW-1:0]        r_period;
    logic [TW-1:0]        w_period_nxt;
    logic signed [31:0]   w_period_raw;
    logic [31:0]          r_dir;
    logic [31:0]          r_pend;
    logic                 r_eng_rst_n;
    logic                 r_step_d;
    logic [15:0]          r_score;
    logic [2:0]           r_level;
    logic [FW-1:0]        r_food;
    logic                 w_ok;
    logic                 w_is_dir;
    logic                 w_opposite;
    logic                 w_dir_ok;
    logic                 w_stay_play;
    logic                 w_start;
    logic                 w_step;

    assign w_ok     = bus.ir_valid && (bus.ir_code == K_OK);
    assign w_is_dir = (bus.ir_code == K_UP)   || (bus.ir_code == K_DOWN) ||
                      (bus.ir_code == K_LEFT) || (bus.ir_code == K_RIGHT);

    // Reversal is judged against the direction the engine is moving, not the pending one
    assign w_opposite = ((bus.ir_code == K_UP)    && (r_dir == K_DOWN))  ||
                        ((bus.ir_code == K_DOWN)  && (r_dir == K_UP))    ||
                        ((bus.ir_code == K_LEFT)  && (r_dir == K_RIGHT)) ||
                        ((bus.ir_code == K_RIGHT) && (r_dir == K_LEFT));
    assign w_dir_ok   = bus.ir_valid && w_is_dir && !w_opposite && (r_state == S_PLAY);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_ok) w_state_nxt = S_PLAY;
            S_PLAY: begin
                if (bus.game_over)  w_state_nxt = S_OVER;
                else if (w_ok)      w_state_nxt = S_PAUSE;
            end
            S_PAUSE: if (w_ok) w_state_nxt = S_PLAY;
            S_OVER:  if (w_ok) w_state_nxt = S_PLAY;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_stay_play = (r_state == S_PLAY) && (w_state_nxt == S_PLAY);
    assign w_start     = ((r_state == S_IDLE) || (r_state == S_OVER)) && (w_state_nxt == S_PLAY);
    // >= so a period that shrinks below the running count still fires on the next cycle
    assign w_step      = !reset && w_stay_play && (r_tick >= (r_period - TW'(1)));

    assign w_period_raw = TICK_START - (TICK_DEC * int'(r_level));

    always_comb begin
        w_period_nxt = TW'(w_period_raw);
        if (w_period_raw < TICK_MIN) w_period_nxt = TW'(TICK_MIN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_tick      <= '0;
            r_period    <= TW'(TICK_START);
            r_dir       <= K_RIGHT;
            r_pend      <= K_RIGHT;
            r_eng_rst_n <= 1'b0;
            r_step_d    <= 1'b0;
            r_score     <= '0;
            r_level     <= '0;
            r_food      <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_eng_rst_n <= (w_state_nxt != S_IDLE);
            r_step_d    <= w_step;
            if (w_start) begin
                r_tick   <= '0;
                r_period <= TW'(TICK_START);
                r_dir    <= K_RIGHT;
                r_pend   <= K_RIGHT;
                r_score  <= '0;
                r_level  <= '0;
                r_food   <= '0;
            end else begin
                r_period <= w_period_nxt;
                if (w_stay_play) r_tick <= w_step ? '0 : (r_tick + TW'(1));
                if (w_step)      r_dir  <= r_pend;
                if (w_dir_ok)    r_pend <= bus.ir_code;
                // Engine reports food the cycle after it moved
                if (r_step_d && bus.food_eaten) begin
                    if (r_score != 16'hFFFF) r_score <= r_score + 16'd1;
                    if (r_food == FW'(FOOD_PER_LV - 1)) begin
                        r_food <= '0;
                        if (r_level < 3'(MAX_LEVEL)) r_level <= r_level + 3'd1;
                    end else begin
                        r_food <= r_food + FW'(1);
                    end
                end
            end
        end
    end

    assign bus.step_en   = w_step;
    assign bus.dir_code  = r_dir;
    assign bus.eng_rst_n = r_eng_rst_n;
    assign bus.state     = r_state;
    assign bus.score     = r_score;
    assign bus.level     = r_level;

endmodule
`default_nettype wire

// File: tb/tb_snake_game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_snake_game_ctrl
//  Description : Directed self-checking bench for snake_game_ctrl with a
//                shortened step period (10 cycles, -1 per level, floor 5).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_snake_game_ctrl;
    localparam logic [31:0] K_UP    = 32'h20DF6A95;
    localparam logic [31:0] K_DOWN  = 32'h20DFEA15;
    localparam logic [31:0] K_LEFT  = 32'h20DF1AE5;
    localparam logic [31:0] K_RIGHT = 32'h20DF9A65;
    localparam logic [31:0] K_OK    = 32'h20DF22DD;

    logic clk;
    logic reset;
    int   errors;
    int   checks;
    int   step_total;

    snake_game_ctrl_if bus();

    snake_game_ctrl #(
        .TICK_START  (10),
        .TICK_DEC    (1),
        .TICK_MIN    (5),
        .FOOD_PER_LV (4),
        .MAX_LEVEL   (7)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (bus.step_en === 1'b1) step_total++;

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic key(input logic [31:0] code);
        bus.ir_code  = code;
        bus.ir_valid = 1'b1;
        cyc();
        bus.ir_valid = 1'b0;
        bus.ir_code  = '0;
    endtask

    // Returns the number of edges until the cycle carrying step_en
    task automatic wait_step(output int n);
        n = 0;
        #1;
        while (bus.step_en !== 1'b1 && n < 50) begin
            @(posedge clk);
            #2;
            n++;
        end
    endtask

    task automatic do_step(input logic food, output int n);
        wait_step(n);
        cyc();
        bus.food_eaten = food;
        cyc();
        bus.food_eaten = 1'b0;
    endtask

    initial begin
        int n;
        int s0;
        int lvl_m;
        int food_m;
        int exp_n;
        errors       = 0;
        checks       = 0;
        step_total   = 0;
        reset        = 1'b1;
        bus.ir_code  = '0;
        bus.ir_valid = 1'b0;
        bus.food_eaten = 1'b0;
        bus.game_over  = 1'b0;
        repeat (3) cyc();
        reset = 1'b0;
        #1;
        chk("rst_state", 32'(bus.state), 32'd0);
        chk("rst_step",  32'(bus.step_en), 32'd0);
        chk("rst_dir",   bus.dir_code, K_RIGHT);
        chk("rst_engn",  32'(bus.eng_rst_n), 32'd0);
        chk("rst_score", 32'(bus.score), 32'd0);
        chk("rst_level", 32'(bus.level), 32'd0);

        // Start and base step period
        key(K_OK);
        chk("start_state", 32'(bus.state), 32'd1);
        chk("start_engn",  32'(bus.eng_rst_n), 32'd1);
        do_step(1'b0, n);
        chk("first_step_wait", 32'(n), 32'd9);
        do_step(1'b0, n);
        chk("period10_wait", 32'(n), 32'd8);

        // Reversal and unknown codes ignored
        key(K_LEFT);
        key(32'h12345678);
        do_step(1'b0, n);
        chk("dir_rev_ignored", bus.dir_code, K_RIGHT);
        key(K_UP);
        key(K_DOWN);
        do_step(1'b0, n);
        chk("dir_last_legal", bus.dir_code, K_DOWN);

        // Pause at tick 5, resume with 5 cycles remaining
        repeat (4) cyc();
        key(K_OK);
        chk("pause_state", 32'(bus.state), 32'd2);
        s0 = step_total;
        key(K_LEFT);
        repeat (99) cyc();
        chk("pause_no_step", 32'(step_total), 32'(s0));
        key(K_OK);
        chk("resume_state", 32'(bus.state), 32'd1);
        do_step(1'b0, n);
        chk("resume_wait", 32'(n), 32'd4);
        chk("pause_dir_ignored", bus.dir_code, K_DOWN);

        // Food, levels and period floor
        lvl_m  = 0;
        food_m = 0;
        for (int i = 0; i < 32; i++) begin
            exp_n = ((10 - lvl_m) < 5 ? 5 : (10 - lvl_m)) - 2;
            do_step(1'b1, n);
            chk($sformatf("lvl_wait_%0d", i), 32'(n), 32'(exp_n));
            food_m++;
            if (food_m == 4) begin
                food_m = 0;
                if (lvl_m < 7) lvl_m++;
            end
            if (i == 3) begin
                chk("score_after4", 32'(bus.score), 32'd4);
                chk("level_after4", 32'(bus.level), 32'd1);
            end
        end
        chk("score_32", 32'(bus.score), 32'd32);
        chk("level_sat", 32'(bus.level), 32'd7);

        // game_over coincident with K_OK in a step cycle
        wait_step(n);
        s0 = step_total;
        bus.game_over = 1'b1;
        bus.ir_code   = K_OK;
        bus.ir_valid  = 1'b1;
        #1;
        chk("over_no_step", 32'(bus.step_en), 32'd0);
        cyc();
        bus.ir_valid = 1'b0;
        bus.ir_code  = '0;
        chk("over_state", 32'(bus.state), 32'd3);
        chk("over_score", 32'(bus.score), 32'd32);
        chk("over_engn",  32'(bus.eng_rst_n), 32'd1);
        repeat (10) cyc();
        chk("over_steps", 32'(step_total), 32'(s0));
        bus.game_over = 1'b0;
        key(K_OK);
        chk("restart_state", 32'(bus.state), 32'd1);
        chk("restart_score", 32'(bus.score), 32'd0);
        chk("restart_level", 32'(bus.level), 32'd0);
        chk("restart_dir",   bus.dir_code, K_RIGHT);
        do_step(1'b1, n);
        chk("restart_wait",  32'(n), 32'd9);
        chk("restart_food",  32'(bus.score), 32'd1);

        // Reset mid-game
        repeat (3) cyc();
        reset = 1'b1;
        cyc();
        chk("midrst_state", 32'(bus.state), 32'd0);
        chk("midrst_step",  32'(bus.step_en), 32'd0);
        chk("midrst_score", 32'(bus.score), 32'd0);
        chk("midrst_engn",  32'(bus.eng_rst_n), 32'd0);
        reset = 1'b0;
        cyc();
        chk("post_rst_state", 32'(bus.state), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
